// File: rtl/tvr_pkg.sv
// Shared definitions for the time value router: FSM states, error codes
// and the BCD field limits used by the optional time-format check.
package tvr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2
  } tvr_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SEL  = 2'b01;
  localparam logic [1:0] ERR_BCD  = 2'b10;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [7:0] BCD_HOUR_MAX  = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX   = 8'h59;
  localparam logic [7:0] BCD_SEC_MAX   = 8'h59;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational check that a 24-bit value is a legal BCD hh:mm:ss time.
// Once every nibble is a decimal digit, plain binary compares on the
// packed BCD fields order the same way as the decimal values.
module bcd_time_check
  import tvr_pkg::*;
(
  input  logic [23:0] value,
  output logic        valid
);

  logic digits_ok;

  // All six nibbles decimal, then range-limit each field.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (value[i*4 +: 4] > BCD_DIGIT_MAX) digits_ok = 1'b0;
    end
    valid = digits_ok &&
            (value[23:16] <= BCD_HOUR_MAX) &&
            (value[15:8]  <= BCD_MIN_MAX) &&
            (value[7:0]   <= BCD_SEC_MAX);
  end

endmodule

// File: rtl/time_value_router.sv
// Routes one time value at a time to a one-hot selected channel register.
// Define TVR_BCD_CHECK_EN to also reject values that are not legal BCD
// hh:mm:ss (requires DATA_W = 24).
//
// state  | meaning
// IDLE   | ready for a transfer; in_data/in_sel captured on accept
// CHECK  | validate captured select (and BCD when enabled)
// COMMIT | write selected channel, pulse ch_load, clear err_code
module time_value_router
  import tvr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [NUM_CH-1:0]        in_sel,
  input  logic [NUM_CH-1:0]        ch_clr,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_load,
  output logic [NUM_CH-1:0]        ch_loaded,
  output logic                     err,
  output logic [1:0]               err_code
);

  tvr_state_e                state_q, state_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [NUM_CH-1:0]         sel_q, sel_d;
  logic [NUM_CH*DATA_W-1:0]  ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]         ch_load_q, ch_load_d;
  logic [NUM_CH-1:0]         ch_loaded_q, ch_loaded_d;
  logic                      err_q, err_d;
  logic [1:0]                err_code_q, err_code_d;
  logic                      sel_ok;
  logic                      data_ok;

  assign sel_ok = $onehot(sel_q);

`ifdef TVR_BCD_CHECK_EN
  bcd_time_check u_bcd_time_check (
    .value (data_q[23:0]),
    .valid (data_ok)
  );
`else
  assign data_ok = 1'b1;
`endif

  // Next-state and output logic; a same-cycle clear loses to a commit set.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    ch_data_d   = ch_data_q;
    ch_load_d   = '0;
    ch_loaded_d = ch_loaded_q & ~ch_clr;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          sel_d   = in_sel;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!sel_ok) begin
          err_d      = 1'b1;
          err_code_d = ERR_SEL;
          state_d    = ST_IDLE;
        end else if (!data_ok) begin
          err_d      = 1'b1;
          err_code_d = ERR_BCD;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel_q[i]) ch_data_d[i*DATA_W +: DATA_W] = data_q;
        end
        ch_load_d   = sel_q;
        ch_loaded_d = (ch_loaded_q & ~ch_clr) | sel_q;
        err_code_d  = ERR_NONE;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      sel_q       <= '0;
      ch_data_q   <= '0;
      ch_load_q   <= '0;
      ch_loaded_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      ch_data_q   <= ch_data_d;
      ch_load_q   <= ch_load_d;
      ch_loaded_q <= ch_loaded_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign ch_data   = ch_data_q;
  assign ch_load   = ch_load_q;
  assign ch_loaded = ch_loaded_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_time_value_router.sv
// Directed and randomized bench for time_value_router (NUM_CH=4, DATA_W=24).
module tb_time_value_router;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 24;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_CH-1:0]        in_sel;
  logic [NUM_CH-1:0]        ch_clr;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_load;
  logic [NUM_CH-1:0]        ch_loaded;
  logic                     err;
  logic [1:0]               err_code;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] m_data [NUM_CH];
  logic [NUM_CH-1:0] m_loaded;
  logic [1:0]        m_code;

  always #5 clk = ~clk;

  time_value_router #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .ch_clr    (ch_clr),
    .ch_data   (ch_data),
    .ch_load   (ch_load),
    .ch_loaded (ch_loaded),
    .err       (err),
    .err_code  (err_code)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] model_vec();
    logic [NUM_CH*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = m_data[i];
    return v;
  endfunction

  // Decimal interpretation of the value, then range checks on the fields.
  function automatic bit bcd_ok(input logic [23:0] v);
    int d [6];
    for (int k = 0; k < 6; k++) begin
      d[k] = int'((v >> (4 * k)) & 24'hF);
      if (d[k] > 9) return 1'b0;
    end
    return ((d[5] * 10 + d[4]) <= 23) && ((d[3] * 10 + d[2]) <= 59) &&
           ((d[1] * 10 + d[0]) <= 59);
  endfunction

  function automatic logic [1:0] expect_code(input logic [3:0] sel, input logic [23:0] data);
    if ($countones(sel) != 1) return 2'b01;
`ifdef TVR_BCD_CHECK_EN
    if (!bcd_ok(data)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic logic [23:0] rand_time();
    int h, m, s;
    h = int'($urandom_range(23, 0));
    m = int'($urandom_range(59, 0));
    s = int'($urandom_range(59, 0));
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] rand_onehot();
    return 4'(1 << $urandom_range(3, 0));
  endfunction

  task automatic model_write(input logic [3:0] sel, input logic [23:0] data, input logic [3:0] clr);
    for (int i = 0; i < NUM_CH; i++) if (sel[i]) m_data[i] = data;
    m_loaded = (m_loaded & ~clr) | sel;
    m_code   = 2'b00;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
    m_loaded = '0;
    m_code   = 2'b00;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_data"}, ch_data, model_vec());
    chk({tag, "_loaded"}, ch_loaded, m_loaded);
    chk({tag, "_code"}, err_code, m_code);
  endtask

  // One full transfer from an idle router, checking every cycle.
  task automatic send(input string tag, input logic [3:0] sel, input logic [23:0] data,
                      input logic [3:0] clr_commit);
    logic [1:0] code;
    code = expect_code(sel, data);
    @(negedge clk);
    chk({tag, "_ready0"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
    in_sel   = 4'($urandom);
    in_data  = 24'($urandom);
    chk({tag, "_ready1"}, in_ready, 1'b0);
    chk({tag, "_load1"}, ch_load, 4'b0);
    chk({tag, "_err1"}, err, 1'b0);
    @(negedge clk);
    if (code != 2'b00) begin
      m_code = code;
      chk({tag, "_errpulse"}, err, 1'b1);
      chk({tag, "_load2"}, ch_load, 4'b0);
      chk({tag, "_ready2"}, in_ready, 1'b1);
      check_state({tag, "_rej"});
      @(negedge clk);
      chk({tag, "_errend"}, err, 1'b0);
      check_state({tag, "_rejhold"});
    end else begin
      chk({tag, "_ready2"}, in_ready, 1'b0);
      chk({tag, "_err2"}, err, 1'b0);
      chk({tag, "_load2"}, ch_load, 4'b0);
      ch_clr = clr_commit;
      @(negedge clk);
      ch_clr = '0;
      model_write(sel, data, clr_commit);
      chk({tag, "_load3"}, ch_load, sel);
      chk({tag, "_ready3"}, in_ready, 1'b1);
      chk({tag, "_err3"}, err, 1'b0);
      check_state({tag, "_commit"});
    end
  endtask

  logic [3:0]  b_sel  [6];
  logic [23:0] b_data [6];
  int          lowc;

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    ch_clr   = '0;
    model_reset();
    #23;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_load", ch_load, 4'b0);
    chk("rst_err", err, 1'b0);
    check_state("rst");
    @(negedge clk);
    resetn = 1'b1;

    send("basic", 4'b0100, 24'h123456, 4'b0000);
    send("multihot", 4'b0110, 24'h010203, 4'b0000);
    send("zerosel", 4'b0000, 24'h020304, 4'b0000);
    send("good_after_err", 4'b0001, 24'h000001, 4'b0000);
    send("bcd_hour", 4'b0010, 24'h245900, 4'b0000);
    send("bcd_nibble", 4'b0010, 24'h1A0000, 4'b0000);
    send("bcd_max", 4'b1000, 24'h235959, 4'b0000);
    send("selprio", 4'b0011, 24'hFFFFFF, 4'b0000);

    // Same-cycle clear loses to the commit; a clear one cycle later wins.
    send("setwins", 4'b0001, 24'h111111, 4'b0001);
    chk("setwins_bit0", ch_loaded[0], 1'b1);
    ch_clr = 4'b0001;
    @(negedge clk);
    ch_clr = '0;
    m_loaded[0] = 1'b0;
    chk("clr_bit0", ch_loaded[0], 1'b0);
    check_state("clr");

    // Back-to-back with in_valid held high: two not-ready cycles per value.
    for (int k = 0; k < 6; k++) begin
      b_sel[k]  = rand_onehot();
      b_data[k] = rand_time();
    end
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_sel  = b_sel[k];
      in_data = b_data[k];
      chk("b2b_ready", in_ready, 1'b1);
      lowc = 0;
      while (lowc < 10) begin
        @(negedge clk);
        if (in_ready) break;
        lowc++;
      end
      chk("b2b_lowcycles", 128'(lowc), 128'd2);
      model_write(b_sel[k], b_data[k], 4'b0000);
      chk("b2b_load", ch_load, b_sel[k]);
      check_state("b2b");
    end
    in_valid = 1'b0;

    // Reset while the router is in CHECK.
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = 4'b0001;
    in_data  = 24'h101010;
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    model_reset();
    chk("rstchk_ready", in_ready, 1'b1);
    chk("rstchk_load", ch_load, 4'b0);
    chk("rstchk_err", err, 1'b0);
    check_state("rstchk");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rstchk_nowrite", ch_data, '0);
    send("after_rst", 4'b0010, 24'h020202, 4'b0000);

    // Randomized transfers and idle clears against the model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  s;
      logic [23:0] d;
      logic [3:0]  c;
      s = ($urandom_range(9, 0) < 7) ? rand_onehot() : 4'($urandom);
      d = ($urandom_range(1, 0) == 1) ? rand_time() : 24'($urandom);
      c = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b0000;
      send("rand", s, d, c);
      if ($urandom_range(3, 0) == 0) begin
        c = 4'($urandom);
        ch_clr = c;
        @(negedge clk);
        ch_clr = '0;
        m_loaded = m_loaded & ~c;
        check_state("rand_clr");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
